mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Sequencing stage that sits directly upstream and downstream of the pipelined wide multiplexer (mux_big).
- On a start pulse it sweeps the mux selector over all C_INPUTS inputs and drives the mux enable.
- It tracks in-flight selections through the mux pipeline and emits each returned value as one beat of an AXI-Stream-style output with index and last flags.
- Backpressure is applied by freezing the mux pipeline through its enable, so the block needs no data FIFO.

Parameters:
- C_WIDTH, 32, data width; must match the mux C_WIDTH.
- C_INPUTS, 4, number of mux inputs to scan; must be ≥1.
- C_LATENCY, 2, mux pipeline depth in enabled cycles (tree depth of the mux instance); must be ≥1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a scan.
- busy  out  1  high from scan acceptance until the last beat is accepted.
- done  out  1  one-cycle pulse after the last beat handshake.
- mux_selector  out  IW=max(1,$clog2(C_INPUTS))  to mux selector.
- mux_enable  out  1  to mux enable.
- mux_value  in  C_WIDTH  from mux value_out.
- m_axis_tdata  out  C_WIDTH  scanned value.
- m_axis_tuser  out  IW  input index of the current beat.
- m_axis_tlast  out  1  marks the beat with index C_INPUTS-1.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Reset clears all registers: busy=0, done=0, mux_selector=0, tvalid=0, tuser=0, tlast=0, state=IDLE.
- Stall rule: mux_enable = ~m_axis_tvalid | m_axis_tready, in every state. All internal tracking registers advance only when mux_enable=1, so they stay in lockstep with the mux pipeline.
- Output data path: m_axis_tdata = mux_value, passed through combinationally from the mux output register.
- Output flags: tvalid, tuser and tlast come from a C_LATENCY-deep shift register of {valid, index}, advanced on mux_enable.
- Combinational paths: none from tready to tvalid, tdata or tuser. tready→mux_enable is the only combinational path.

States:
- IDLE: start=1 → SCAN, issue_idx=0, busy=1 at the next edge. Otherwise remain.
- SCAN: each cycle with mux_enable=1 issues mux_selector=issue_idx (registered output) and pushes {1, issue_idx} into the shift register.
  - If issue_idx=C_INPUTS-1 → DRAIN; otherwise increment issue_idx.
  - With mux_enable=0 nothing is issued and nothing changes.
- DRAIN: cycles with mux_enable=1 push {0, x}. The handshake with tlast=1 → IDLE, busy=0, done=1 for exactly one cycle.

Timing:
- First beat: tvalid rises C_LATENCY enabled cycles after the first issue.
- Throughput: with tready held high, beats are back-to-back, and the total scan takes 1 + C_INPUTS + C_LATENCY cycles from start to done.

Boundary conditions:
- start while busy: ignored.
- start in the same cycle as done: accepted; the new scan begins.
- C_INPUTS=1: a single beat with tuser=0 and tlast=1.
- tready held low: tvalid, tdata and tuser are held stable; the mux is frozen; no beat is lost or duplicated.
- Reset mid-scan: the scan is aborted; tvalid drops immediately; done is not pulsed.
- Selector range: mux_selector never exceeds C_INPUTS-1.

Optional Feature:
- Macro: MUX_SCAN_CTRL_ABORT_EN.
- When defined: an extra input port abort is added. abort=1 in SCAN or DRAIN, at the next edge:
  - clears the shift register and tvalid;
  - returns to IDLE with busy=0;
  - does not pulse done.
  
  abort takes priority over a simultaneous beat handshake; that beat counts as not delivered.
- When undefined: no abort port; a scan always runs to completion.

Decomposition:
- Package mux_scan_pkg holds:
  - the state enum (IDLE, SCAN, DRAIN);
  - function idx_width(n) returning max(1,$clog2(n));
  - a packed struct for the shift-register entry {valid, index}.
- Sub-module mux_scan_track: the C_LATENCY-deep enable-gated {valid, index} delay line. It is reusable for any enable-stalled pipeline.

Test Plan:
- C_INPUTS=4, C_LATENCY=2, inputs 0xA0..0xA3, tready=1, pulse start → 4 consecutive beats A0..A3, tuser 0..3, tlast on the 4th beat, done exactly 7 cycles after start.
- Same setup, tready toggling 1,0,0,1,… → every beat appears exactly once, in order; tdata and tuser stable while tready=0; mux_enable=0 exactly on stalled cycles.
- start pulsed during busy and again in the done cycle → the first extra start is ignored; the second launches a full new 4-beat scan.
- C_INPUTS=1, C_LATENCY=1 → a single beat with tuser=0, tlast=1, done 3 cycles after start.
- Reset asserted after the 2nd beat → tvalid=0 and busy=0 immediately; no done; a new start after release gives beats from index 0.
- With MUX_SCAN_CTRL_ABORT_EN defined, abort in DRAIN with tvalid=1 and tready=1 → no handshake counted, IDLE next cycle, done=0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types for the mux scan controller: FSM states, tracking-entry layout
// and the index-width helper.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } scan_state_t;

  // Fixed so the struct can live in a package; designs index at most 2**16 inputs.
  localparam int TRK_IDX_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [TRK_IDX_W-1:0] index;
  } trk_entry_t;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_track.sv
// Enable-gated {valid, index} delay line that mirrors an enable-stalled pipeline
// stage for stage; clr flushes every entry regardless of enable.
module mux_scan_track
  import mux_scan_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  trk_entry_t din,
  output trk_entry_t dout
);

  trk_entry_t dly [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) dly[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < STAGES; i++) dly[i] <= '0;
    end else if (en) begin
      dly[0] <= din;
      for (int i = 1; i < STAGES; i++) dly[i] <= dly[i-1];
    end
  end

  assign dout = dly[STAGES-1];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sweeps the pipelined mux selector over all inputs and streams the returned values
// as indexed beats. Optional abort input enabled by macro MUX_SCAN_CTRL_ABORT_EN.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter  int C_WIDTH   = 32,
  parameter  int C_INPUTS  = 4,
  parameter  int C_LATENCY = 2,
  localparam int IW        = idx_width(C_INPUTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef MUX_SCAN_CTRL_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  output logic [IW-1:0]      mux_selector,
  output logic               mux_enable,
  input  logic [C_WIDTH-1:0] mux_value,
  output logic [C_WIDTH-1:0] m_axis_tdata,
  output logic [IW-1:0]      m_axis_tuser,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready
);

  localparam logic [IW-1:0]        LAST_IDX     = IW'(C_INPUTS - 1);
  localparam logic [TRK_IDX_W-1:0] LAST_IDX_TRK = TRK_IDX_W'(C_INPUTS - 1);

  scan_state_t   state;
  logic [IW-1:0] issue_idx;
  logic          iss_vld;
  logic          abort_req;
  logic          last_hs;
  trk_entry_t    trk_in;
  trk_entry_t    trk_out;

`ifdef MUX_SCAN_CTRL_ABORT_EN
  assign abort_req = abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // Freezing the mux through its enable is the only backpressure mechanism.
  assign mux_enable    = ~m_axis_tvalid | m_axis_tready;
  assign m_axis_tdata  = mux_value;
  assign m_axis_tvalid = trk_out.valid;
  assign m_axis_tuser  = trk_out.index[IW-1:0];
  assign m_axis_tlast  = trk_out.valid && (trk_out.index == LAST_IDX_TRK);
  assign last_hs       = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // mux_selector/iss_vld form the issue stage; the mux samples the selector one
  // enabled edge later, so the delay line behind it is exactly C_LATENCY deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      mux_selector <= '0;
      issue_idx    <= '0;
      iss_vld      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_req) begin
        state   <= IDLE;
        busy    <= 1'b0;
        iss_vld <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= SCAN;
              busy      <= 1'b1;
              issue_idx <= '0;
            end
          end
          SCAN: begin
            if (mux_enable) begin
              mux_selector <= issue_idx;
              iss_vld      <= 1'b1;
              if (issue_idx == LAST_IDX) state <= DRAIN;
              else                       issue_idx <= issue_idx + IW'(1);
            end
          end
          DRAIN: begin
            if (mux_enable) iss_vld <= 1'b0;
            if (last_hs) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign trk_in = '{valid: iss_vld, index: TRK_IDX_W'(mux_selector)};

  mux_scan_track #(
    .STAGES(C_LATENCY)
  ) u_track (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (mux_enable),
    .clr  (abort_req),
    .din  (trk_in),
    .dout (trk_out)
  );

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a 4-input/latency-2 instance checked every cycle
// against a beat-level model, plus a 1-input/latency-1 instance checked by literals.
`timescale 1ns/1ps
module tb_mux_scan_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic          start = 1'b0, tready = 1'b1, abort = 1'b0;
  logic          busy, done, en, tvalid, tlast;
  logic [1:0]    sel, tuser;
  logic [W-1:0]  mux_value, tdata;
  logic [W-1:0]  mp [2];

  logic          start1 = 1'b0, tready1 = 1'b1;
  logic          busy1, done1, en1, tvalid1, tlast1, sel1, tuser1;
  logic [W-1:0]  mux_value1, tdata1, mp1;

  mux_scan_ctrl #(.C_WIDTH(W), .C_INPUTS(4), .C_LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef MUX_SCAN_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .mux_selector(sel), .mux_enable(en),
    .mux_value(mux_value), .m_axis_tdata(tdata), .m_axis_tuser(tuser),
    .m_axis_tlast(tlast), .m_axis_tvalid(tvalid), .m_axis_tready(tready)
  );

  mux_scan_ctrl #(.C_WIDTH(W), .C_INPUTS(1), .C_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef MUX_SCAN_CTRL_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy1), .done(done1), .mux_selector(sel1), .mux_enable(en1),
    .mux_value(mux_value1), .m_axis_tdata(tdata1), .m_axis_tuser(tuser1),
    .m_axis_tlast(tlast1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready1)
  );

  // Environment: enable-gated mux pipelines, inputs 0xA0+i and 0x5A.
  initial begin mp[0] = '0; mp[1] = '0; mp1 = '0; end
  always @(posedge clk) if (en) begin mp[0] <= 32'hA0 + 32'(sel); mp[1] <= mp[0]; end
  always @(posedge clk) if (en1) mp1 <= 32'h5A + 32'(sel1);
  assign mux_value  = mp[1];
  assign mux_value1 = mp1;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat-level model: busy window, next expected beat index, done pulse, stall hold.
  bit          busy_m = 0, done_m = 0, stall_prev = 0;
  int          exp_idx = 0, done_count = 0, first_vld_cyc = -1, done_cyc = -1;
  int          en_low = 0, stalls = 0;
  logic [31:0] prev_data = '0;
  logic [1:0]  prev_user = '0;
  logic [31:0] beats [$];

  always @(negedge clk) begin : monitor
    bit hs, last_m, ab;
    if (!rst_n) begin
      chk("rst_tvalid", tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sel", sel, 0);
      chk("rst_tuser", tuser, 0);
      chk("rst_tlast", tlast, 0);
      busy_m = 0; done_m = 0; exp_idx = 0; stall_prev = 0;
    end else begin
      chk("enable", en, !tvalid || tready);
      chk("busy", busy, busy_m);
      chk("done", done, done_m);
      if (tvalid) begin
        chk("beat_tuser", tuser, exp_idx);
        chk("beat_tdata", tdata, 32'hA0 + exp_idx);
        chk("beat_tlast", tlast, exp_idx == 3);
      end else begin
        chk("idle_tlast", tlast, 0);
      end
      if (stall_prev) begin
        chk("hold_tvalid", tvalid, 1);
        chk("hold_tdata", tdata, prev_data);
        chk("hold_tuser", tuser, prev_user);
      end
      ab     = abort && busy_m;
      hs     = tvalid && tready && !ab;
      last_m = hs && (exp_idx == 3);
      if (tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (done) begin done_count++; done_cyc = cyc; end
      if (!en) en_low++;
      if (tvalid && !tready) stalls++;
      if (hs) beats.push_back(tdata);
      stall_prev = tvalid && !tready && !ab;
      prev_data  = tdata;
      prev_user  = tuser;
      done_m     = last_m;
      if (ab || last_m)        busy_m = 0;
      else if (!busy_m && start) busy_m = 1;
      if (ab)      exp_idx = 0;
      else if (hs) exp_idx = (exp_idx + 1) % 4;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int max, input string name);
    int d0 = done_count;
    for (int i = 0; i < max && done_count == d0; i++) step();
    chk({name, "_done_timeout"}, done_count == d0, 0);
  endtask

  task automatic chk_beats(input string name, input int n);
    chk({name, "_nbeats"}, beats.size(), n);
    for (int k = 0; k < n && k < beats.size(); k++) chk({name, "_beat"}, beats[k], 32'hA0 + (k % 4));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int acc, d0, e0, s0;
    bit got;
    logic v1 [6], dn1 [6], b1 [6], u1 [6], l1 [6];
    logic [W-1:0] dt1 [6];

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(); step();

    // Back-to-back scan with tready high.
    beats.delete(); first_vld_cyc = -1;
    start = 1; acc = cyc + 1; step(); start = 0;
    wait_done(30, "t1");
    chk("t1_first_beat_latency", first_vld_cyc - acc, 3);
    chk("t1_done_latency", done_cyc - acc, 7);
    chk_beats("t1", 4);

    // tready pattern 1,0,0,1,...
    beats.delete(); step();
    e0 = en_low; s0 = stalls; d0 = done_count;
    start = 1; step(); start = 0;
    for (int i = 0; i < 60 && done_count == d0; i++) begin
      tready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    tready = 1;
    chk("t2_done_timeout", done_count == d0, 0);
    chk_beats("t2", 4);
    chk("t2_stalls_seen", stalls > s0, 1);
    chk("t2_enable_low_eq_stalls", en_low - e0, stalls - s0);

    // Start during busy (ignored) and in the done cycle (accepted).
    beats.delete(); step();
    d0 = done_count;
    start = 1; step(); start = 0;
    step(); step();
    start = 1; step(); start = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin step(); if (done) got = 1; end
    chk("t3_first_done_seen", got, 1);
    start = 1; step(); start = 0;
    wait_done(30, "t3b");
    chk_beats("t3", 8);
    chk("t3_done_count", done_count - d0, 2);

    // Single-input, latency-1 instance.
    start1 = 1; step(); start1 = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      v1[k] = tvalid1; dn1[k] = done1; b1[k] = busy1; u1[k] = tuser1; l1[k] = tlast1; dt1[k] = tdata1;
    end
    chk("t4_busy_k1", b1[1], 1);
    chk("t4_tvalid_k2", v1[2], 0);
    chk("t4_tvalid_k3", v1[3], 1);
    chk("t4_tuser_k3", u1[3], 0);
    chk("t4_tlast_k3", l1[3], 1);
    chk("t4_tdata_k3", dt1[3], 32'h5A);
    chk("t4_tvalid_k4", v1[4], 0);
    chk("t4_done_k3", dn1[3], 0);
    chk("t4_done_k4", dn1[4], 1);
    chk("t4_busy_k4", b1[4], 0);
    chk("t4_done_k5", dn1[5], 0);

    // Reset after the second beat.
    beats.delete(); step();
    start = 1; step(); start = 0;
    for (int i = 0; i < 30 && beats.size() < 2; i++) step();
    chk("t5_two_beats", beats.size(), 2);
    d0 = done_count;
    rst_n = 0; #1;
    chk("t5_tvalid_in_reset", tvalid, 0);
    chk("t5_busy_in_reset", busy, 0);
    step(); step(); rst_n = 1; step();
    repeat (8) step();
    chk("t5_no_done", done_count - d0, 0);
    beats.delete();
    start = 1; step(); start = 0;
    wait_done(30, "t5b");
    chk_beats("t5", 4);

`ifdef MUX_SCAN_CTRL_ABORT_EN
    // Abort while the last beat is being accepted.
    beats.delete(); step();
    start = 1; step(); start = 0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin step(); if (tvalid && tuser == 2'd3) got = 1; end
    chk("t6_last_beat_seen", got, 1);
    d0 = done_count;
    abort = 1; step(); abort = 0;
    chk("t6_tvalid_after_abort", tvalid, 0);
    chk("t6_busy_after_abort", busy, 0);
    chk("t6_done_after_abort", done, 0);
    repeat (5) step();
    chk("t6_no_done", done_count - d0, 0);
    chk_beats("t6", 3);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
